// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions and transmitter state encoding.
package mmio_pkg;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // STATUS only has a 4-bit count field, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'd15 : cnt[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes core stores into TXDATA/STATUS,
// queues bytes in a FIFO and serialises them LSB first.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0800,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;

    logic          w_is_status;
    logic          w_wr_txdata;
    logic          w_wr_status;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_fifo_dout;
    logic          w_baud_done;
    logic          w_pop;
    logic [31:0]   w_status;
    logic          w_unused_bits;

    // Address decode: 8-byte window, word offset in address[2].
    assign sel         = (address[31:3] == BASE_ADDR[31:3]);
    assign w_is_status = (address[2] == STATUS_OFS[2]);
    assign w_wr_txdata = we && sel && (address[2] == TXDATA_OFS[2]);
    assign w_wr_status = we && sel && w_is_status;
    assign w_unused_bits = ^{address[1:0], data_in[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_txdata),
        .i_din   (data_in[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

    assign tx      = r_tx;
    assign tx_busy = (r_state != ST_IDLE) || !w_empty;

    // A set in the same cycle as a clear wins, so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txdata && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && data_in[STAT_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                              = '0;
        w_status[STAT_FULL]                   = w_full;
        w_status[STAT_EMPTY]                  = w_empty;
        w_status[STAT_BUSY]                   = tx_busy;
        w_status[STAT_OVF]                    = r_ovf;
        w_status[STAT_CNT_LSB+3:STAT_CNT_LSB] = sat_count4(32'(w_count));
    end

    assign rdata = (sel && w_is_status) ? w_status : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        // Chain straight into the next START when a byte waits.
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus-write stimulus, a serial receiver that decodes
// frames and compares them against a queue of expected bytes.
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        we;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    int          n_checks;
    int          n_errors;
    int          cyc;
    bit          mon_en;
    bit          rx_act;
    int          rx_cnt;
    logic [7:0]  rx_byte;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_0800),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data_in (data_in),
        .we      (we),
        .sel     (sel),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Receiver: first low sample marks the start bit; later samples land mid-bit.
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2) begin
                chk("rx_start_bit", {31'h0, tx}, 32'h0);
            end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
                rx_byte[(rx_cnt - 6) / 4] = tx;
            end else if (rx_cnt == 38) begin
                chk("rx_stop_bit", {31'h0, tx}, 32'h1);
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", {24'h0, rx_byte}, 32'h100);
                end else begin
                    chk("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
                end
                rx_act = 1'b0;
            end
        end
    end

    // Called at a negedge; the write lands on the following rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        address = addr;
        data_in = data;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
        address = 32'h0;
        data_in = 32'h0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (!tx_busy) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) chk("idle_timeout", {31'h0, tx_busy}, 32'h0);
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp_v);
        address = 32'h0000_0804;
        #1;
        chk(tag, rdata, exp_v);
        address = 32'h0;
    endtask

    initial begin
        int base;
        int frames;
        int low_cnt;
        logic [9:0] pat;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        address  = 32'h0;
        data_in  = 32'h0;
        we       = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_busy", {31'h0, tx_busy}, 32'h0);
        address = 32'h0000_0804;
        #1;
        chk("rst_sel", {31'h0, sel}, 32'h1);
        chk("rst_status", rdata, 32'h0000_0002);
        address = 32'h0;

        // Single frame 0x55 with bit-level timing
        exp_q.push_back(8'h55);
        pat = 10'b1_0101_0101_0;
        wr(32'h0000_0800, 32'h55);
        chk("f55_tx_e0", {31'h0, tx}, 32'h1);
        chk("f55_busy_e0", {31'h0, tx_busy}, 32'h1);
        @(negedge clk);
        chk("f55_bit0", {31'h0, tx}, {31'h0, pat[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clk);
            chk($sformatf("f55_bit%0d", k), {31'h0, tx}, {31'h0, pat[k]});
        end
        repeat (3) @(negedge clk);
        chk("f55_busy_last", {31'h0, tx_busy}, 32'h1);
        @(negedge clk);
        chk("f55_busy_end", {31'h0, tx_busy}, 32'h0);
        chk("f55_tx_end", {31'h0, tx}, 32'h1);

        // Three back-to-back frames
        base = start_q.size();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hFF);
        wr(32'h0000_0800, 32'hA3);
        wr(32'h0000_0800, 32'h0F);
        wr(32'h0000_0800, 32'hFF);
        wait_idle(200);
        repeat (2) @(negedge clk);
        chk("b2b_frames", 32'(start_q.size() - base), 32'd3);
        if (start_q.size() >= base + 3) begin
            chk("b2b_gap1", 32'(start_q[base+1] - start_q[base]), 32'd40);
            chk("b2b_gap2", 32'(start_q[base+2] - start_q[base+1]), 32'd40);
        end

        // Overflow: ten writes, nine accepted
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 10; i++) wr(32'h0000_0800, 32'(32'h10 + i));
        read_status("ovf_status", 32'h0000_008D);
        wr(32'h0000_0804, 32'h8);
        read_status("ovf_cleared", 32'h0000_0085);
        wait_idle(450);
        repeat (2) @(negedge clk);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame with two bytes queued
        wr(32'h0000_0800, 32'h3C);
        wr(32'h0000_0800, 32'h11);
        wr(32'h0000_0800, 32'h22);
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        chk("mrst_tx", {31'h0, tx}, 32'h1);
        chk("mrst_busy", {31'h0, tx_busy}, 32'h0);
        read_status("mrst_status", 32'h0000_0002);
        frames  = start_q.size();
        mon_en  = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        chk("mrst_tx_quiet", 32'(low_cnt), 32'd0);
        chk("mrst_no_frames", 32'(start_q.size() - frames), 32'd0);

        // Decode boundaries and the ignored byte offset
        address = 32'h0000_07FC;
        #1;
        chk("alias_lo_sel", {31'h0, sel}, 32'h0);
        chk("alias_lo_rdata", rdata, 32'h0);
        address = 32'h0000_0808;
        #1;
        chk("alias_hi_sel", {31'h0, sel}, 32'h0);
        address = 32'h0000_0800;
        #1;
        chk("txdata_read", rdata, 32'h0);
        address = 32'h0;
        wr(32'h0000_07FC, 32'h77);
        wr(32'h0000_0808, 32'h66);
        read_status("alias_status", 32'h0000_0002);
        exp_q.push_back(8'h5A);
        wr(32'h0000_0802, 32'h5A);
        chk("ofs2_busy", {31'h0, tx_busy}, 32'h1);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        read_status("final_status", 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data bus, alongside `memory`. It decodes core stores into a small I/O window, queues bytes in a FIFO and shifts them out as 8N1 serial frames. It turns the core's MMIO console writes into a real serial stream the bench or an FPGA pin can consume.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0800: base of the 8-byte register window; must be 8-byte aligned.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; minimum 2.
- `FIFO_DEPTH`, 8: byte entries; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  32  core bus address (same net that drives `memory`).
- `data_in`  in  32  core store data (the core's `data_out`).
- `we`  in  1  core write strobe.
- `sel`  out  1  combinational: `address[31:3] == BASE_ADDR[31:3]`.
- `rdata`  out  32  combinational read data, valid while `sel`.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Register map, word addressed; `address[1:0]` is ignored:
  - TXDATA at +0. A write (`we & sel`) pushes `data_in[7:0]`. Reads return 0.
  - STATUS at +4. Read layout:
    - bit0 full, bit1 empty, bit2 `tx_busy`, bit3 overflow (sticky).
    - bits[7:4] FIFO count, saturating at 15.
    - Other bits 0.
  - Writing STATUS with `data_in[3]=1` clears overflow. Other bits are ignored.
- Write to TXDATA while full: byte dropped, overflow set, FIFO unchanged.
- Push while full in the same cycle the transmitter pops: the push is accepted and the count is unchanged.
- Transmitter FSM, with bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1:
  - IDLE: `tx`=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first. Shift every CLKS_PER_BIT cycles; after 8 bits go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- The pop is registered. The FIFO empty flag reflects the post-pop state on the next cycle.

## Timing
- Reset values:
  - FSM in IDLE, `tx`=1, FIFO empty.
  - Overflow 0, `tx_busy`=0.
  - `rdata` is STATUS = 32'h0000_0002 when STATUS is selected.
- Reset mid-frame aborts the frame: `tx` goes to 1 on the cycle after the reset edge, and the FIFO contents are discarded.
- Write accepted on rising edge E. FIFO count updates at E. The pop and START entry happen at E+1, so `tx` falls for the cycle after E+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. With a backlog, the frame period is 10·CLKS_PER_BIT with no gaps.
- `tx_busy` rises the cycle after E. It falls the cycle after STOP completes with the FIFO empty.
- `rdata` and `sel` are purely combinational, with zero latency, matching the core's read timing for `memory`.
- `sel` must gate any write-enable the integrator sends to `memory`, so I/O stores do not alias RAM.

## Structure
- Shared package `mmio_pkg`:
  - register offsets `TXDATA_OFS`=0, `STATUS_OFS`=4;
  - STATUS bit indices;
  - FSM state encoding IDLE/START/DATA/STOP.
- One sub-module, `sync_fifo` (parameters WIDTH=8, DEPTH), with push/pop/full/empty/count. The rest is the FSM and decode in `mmio_uart_tx`.
- Target size: about 200 lines total.

## Test plan
Parameters CLKS_PER_BIT=4, FIFO_DEPTH=8 unless stated.
- Reset, then idle for 20 cycles → `tx`=1, `tx_busy`=0, STATUS read at 0x804 = 0x0000_0002.
- Store 0x55 to 0x800 → `tx` low 2 cycles after the write edge. Sampled every 4 cycles: 0,1,0,1,0,1,0,1,0,1. Total 40 cycles, then `tx_busy`=0.
- Store 0xA3, 0x0F, 0xFF on consecutive writes → three frames back-to-back, 120 cycles with no idle gap; decoded bytes A3, 0F, FF.
- Store 10 bytes with no gaps before the first pop → exactly 9 bytes accepted: the first byte is popped one cycle later and 8 remain queued. STATUS shows full=1, overflow=1; the 10th byte never appears on `tx`. Store 0x8 to 0x804 → overflow clears.
- Assert `reset` mid-DATA of frame 0x3C with 2 bytes queued → `tx`=1 next cycle, STATUS=0x2, no further frames.
- Store to 0x7FC and 0x808 → `sel`=0, FIFO untouched. Store to 0x802 → treated as TXDATA.
